// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: synthetic detector-pulse source for the shaping filter input.
// Each accepted start produces a linear rise to a programmable amplitude
// followed by an exponential decay back to baseline, one sample per clock.
// Optional feature: define PULSE_GEN_PILEUP_EN to accept new pulses while one
// is in progress (pile-up emulation); the default build has no pile-up logic.
module v1_pulse_gen #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int FRAC          = 8,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int BASELINE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [SIZE_ADC_DATA-2:0]        amplitude,
    output logic signed [SIZE_ADC_DATA-1:0] output_data,
    output logic                            ready,
    output logic                            busy,
    output logic [15:0]                     pulse_cnt
);

    localparam int AW       = SIZE_ADC_DATA + FRAC;
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam int CW       = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    // Two headroom bits so baseline plus any accumulator level cannot wrap.
    localparam int SW       = SIZE_ADC_DATA + 2;

    localparam logic [AW-1:0]        ONE_INT   = AW'(1 << FRAC);
    localparam logic [CW-1:0]        RISE_LAST = CW'(RISE_LEN - 1);
    localparam logic signed [SW-1:0] BASE_EXT  = SW'(BASELINE);
    localparam logic signed [SW-1:0] SAT_MAX   = SW'((1 << (SIZE_ADC_DATA - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN   = SW'(-(1 << (SIZE_ADC_DATA - 1)));
`ifdef PULSE_GEN_PILEUP_EN
    localparam logic [AW-1:0]        ACC_MAX   = AW'(((1 << SIZE_ADC_DATA) - 1) << FRAC);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic [AW-1:0]   step, step_nxt;
    logic [AW-1:0]   peak, peak_nxt;
    logic [CW-1:0]   rise_cnt, rise_cnt_nxt;
    logic [15:0]     pulse_cnt_nxt;
    logic [AW-1:0]   amp_fix;
    logic [AW-1:0]   dec;
`ifdef PULSE_GEN_PILEUP_EN
    logic [AW:0]     pile_sum;
    logic [AW-1:0]   pile_peak;
`endif

    // Adds the signed baseline to the integer level and clamps to the ADC range.
    function automatic logic signed [SIZE_ADC_DATA-1:0] sat_sample(
        input logic [SIZE_ADC_DATA-1:0] level
    );
        logic signed [SW-1:0] sum;
        sum = BASE_EXT + $signed({2'b00, level});
        if (sum > SAT_MAX) begin
            return SAT_MAX[SIZE_ADC_DATA-1:0];
        end else if (sum < SAT_MIN) begin
            return SAT_MIN[SIZE_ADC_DATA-1:0];
        end
        return sum[SIZE_ADC_DATA-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and pulse-shape arithmetic.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        step_nxt      = step;
        peak_nxt      = peak;
        rise_cnt_nxt  = rise_cnt;
        pulse_cnt_nxt = pulse_cnt;
        amp_fix       = AW'(amplitude) << FRAC;
        dec           = acc >> DECAY_SHIFT;
        if (dec == '0) begin
            dec = AW'(1);
        end
        busy          = (state != IDLE);
`ifdef PULSE_GEN_PILEUP_EN
        ready         = 1'b1;
        pile_sum      = {1'b0, acc} + {1'b0, amp_fix};
        pile_peak     = (pile_sum > {1'b0, ACC_MAX}) ? ACC_MAX : pile_sum[AW-1:0];
`else
        ready         = (state == IDLE);
`endif

        case (state)
            IDLE: begin
                acc_nxt = '0;
            end
            RISE: begin
                rise_cnt_nxt = rise_cnt + CW'(1);
                if (rise_cnt == RISE_LAST) begin
                    // Land exactly on the peak to absorb step truncation.
                    acc_nxt   = peak;
                    state_nxt = DECAY;
                end else begin
                    acc_nxt = acc + step;
                end
            end
            DECAY: begin
                if (acc < ONE_INT) begin
                    acc_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = acc - dec;
                end
            end
            default: begin
                acc_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        // Accept overrides the per-state update; the rise starts from the current level.
        if (start && ready) begin
            pulse_cnt_nxt = pulse_cnt + 16'd1;
            rise_cnt_nxt  = '0;
            acc_nxt       = acc;
            state_nxt     = RISE;
`ifdef PULSE_GEN_PILEUP_EN
            peak_nxt      = pile_peak;
            step_nxt      = (pile_peak - acc) >> RISE_SHIFT;
`else
            peak_nxt      = amp_fix;
            step_nxt      = amp_fix >> RISE_SHIFT;
`endif
        end
    end

    // Pulse accumulator, rise bookkeeping and pulse counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            step      <= '0;
            peak      <= '0;
            rise_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            acc       <= acc_nxt;
            step      <= step_nxt;
            peak      <= peak_nxt;
            rise_cnt  <= rise_cnt_nxt;
            pulse_cnt <= pulse_cnt_nxt;
        end
    end

    // Output stage: registered baseline-shifted, saturated sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            output_data <= sat_sample('0);
        end else begin
            output_data <= sat_sample(acc[AW-1:FRAC]);
        end
    end

endmodule

// File: tb/tb_v1_pulse_gen.sv
// Scoreboard bench for v1_pulse_gen: two instances (BASELINE 0 and 1500)
// share stimulus; a reference model builds each pulse as a list of levels.
module tb_v1_pulse_gen;

    localparam int N     = 12;
    localparam int AMP_W = N - 1;
    localparam int FRAC  = 8;
    localparam int RS    = 2;
    localparam int DS    = 4;
    localparam int B1    = 1500;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic [AMP_W-1:0]        amplitude = '0;
    logic signed [N-1:0]     out0, out1;
    logic                    rdy0, rdy1, busy0, busy1;
    logic [15:0]             cnt0, cnt1;

    typedef struct {
        int o0;
        int o1;
        int rdy;
        int bsy;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    int   m_lvls[$];
    int   m_acc = 0;
    int   m_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    v1_pulse_gen #(
        .SIZE_ADC_DATA(N), .FRAC(FRAC), .RISE_SHIFT(RS), .DECAY_SHIFT(DS), .BASELINE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
        .output_data(out0), .ready(rdy0), .busy(busy0), .pulse_cnt(cnt0)
    );

    v1_pulse_gen #(
        .SIZE_ADC_DATA(N), .FRAC(FRAC), .RISE_SHIFT(RS), .DECAY_SHIFT(DS), .BASELINE(B1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .amplitude(amplitude),
        .output_data(out1), .ready(rdy1), .busy(busy1), .pulse_cnt(cnt1)
    );

    function automatic int sat_ref(input int base, input int acc);
        int v;
        v = base + (acc >> FRAC);
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    // Whole-pulse shape: rise levels, exact peak, geometric decay, final zero.
    function automatic void build_pulse(input int amp);
        int peak;
        int stp;
        int a;
        int d;
        peak = amp << FRAC;
        stp  = peak >> RS;
        for (int k = 1; k < (1 << RS); k++) m_lvls.push_back(k * stp);
        m_lvls.push_back(peak);
        a = peak;
        while (a >= (1 << FRAC)) begin
            d = a >> DS;
            if (d == 0) d = 1;
            a = a - d;
            m_lvls.push_back(a);
        end
        m_lvls.push_back(0);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Reference model: one expected record per rising edge.
    always @(posedge clk) begin
        exp_t e;
        int   prev;
        if (!reset) begin
            m_lvls.delete();
            m_acc = 0;
            m_cnt = 0;
            e.o0  = sat_ref(0, 0);
            e.o1  = sat_ref(B1, 0);
            e.rdy = 1;
            e.bsy = 0;
            e.cnt = 0;
        end else begin
            prev = m_acc;
            if (m_lvls.size() == 0) begin
                if (start) begin
                    build_pulse(int'(amplitude));
                    m_cnt = (m_cnt + 1) % 65536;
                end
                m_acc = 0;
            end else begin
                m_acc = m_lvls.pop_front();
            end
            e.o0  = sat_ref(0, prev);
            e.o1  = sat_ref(B1, prev);
            e.bsy = (m_lvls.size() != 0) ? 1 : 0;
            e.rdy = 1 - e.bsy;
            e.cnt = m_cnt;
        end
        sbq.push_back(e);
    end

    // Monitor: pop and compare after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("out_b0",   int'(out0), e.o0);
                check("out_b1500", int'(out1), e.o1);
                check("ready0",   int'(rdy0), e.rdy);
                check("busy0",    int'(busy0), e.bsy);
                check("cnt0",     int'(cnt0), e.cnt);
                check("ready1",   int'(rdy1), e.rdy);
                check("busy1",    int'(busy1), e.bsy);
                check("cnt1",     int'(cnt1), e.cnt);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic fire(input int amp);
        @(negedge clk);
        start     = 1'b1;
        amplitude = AMP_W'(amp);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Stimulus.
    initial begin
        int nb;
        int hold;
        int r;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Single pulse, amplitude 1000.
        fire(1000);
        wait_idle(400);

        // Start during decay must be ignored.
        fire(1000);
        repeat (8) @(negedge clk);
        start = 1'b1;
        amplitude = AMP_W'(500);
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(400);

        // Full-scale amplitude: the BASELINE=1500 instance clamps at 2047.
        fire(2047);
        wait_idle(400);

        // Asynchronous reset three cycles into decay.
        fire(1000);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out0", int'(out0), 0);
        check("async_rst_out1", int'(out1), B1);
        check("async_rst_ready", int'(rdy0), 1);
        check("async_rst_busy", int'(busy0), 0);
        check("async_rst_cnt", int'(cnt0), 0);
        @(negedge clk);
        reset = 1'b1;
        fire(1000);
        wait_idle(400);

        // Zero amplitude: busy for exactly RISE_LEN+1 cycles.
        fire(0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) nb++;
            @(negedge clk);
        end
        check("amp0_busy_len", nb, 5);

        // Start held high: back-to-back pulses.
        @(negedge clk);
        start = 1'b1;
        amplitude = AMP_W'(300);
        repeat (300) @(negedge clk);
        start = 1'b0;
        wait_idle(400);

        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            r = $urandom_range(0, 9);
            if (hold > 0) begin
                hold--;
                start = 1'b1;
            end else begin
                start = (r == 0);
                if (r == 1) hold = $urandom_range(5, 60);
            end
            case ($urandom_range(0, 5))
                0:       amplitude = '0;
                1:       amplitude = '1;
                default: amplitude = AMP_W'($urandom);
            endcase
        end
        start = 1'b0;
        wait_idle(400);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
